// File: rtl/if_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue, with the flush and status lines.
// The master side is the pipeline (fetch, decode, execute); the slave side is the queue.
interface if_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_instr;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_pc_plus_4;
  logic [CNT_W-1:0] count;
  logic             almost_full;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pc_plus_4, count, almost_full
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc_plus_4, count, almost_full
  );
endinterface

// File: rtl/if_queue.sv
// DEPTH-entry circular instruction queue between fetch and decode holding {instr, pc, pc+4}.
// Flush clears it in one cycle; an empty queue presents an all-zero bubble to decode.
module if_queue #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic       clk,
  input  logic       reset,
  if_queue_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_s, empty_s, enq_s, deq_s;
  entry_t           head_s;

  assign full_s  = (count_q == CNT_W'(DEPTH));
  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign enq_s   = q.in_valid && !full_s;
  assign deq_s   = !empty_s && q.out_ready;
  assign head_s  = mem_q[rd_ptr_q];

  // Pointer/count next state; flush overrides any handshake in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is deliberately left unreset; the count gate hides stale contents.
  always_ff @(posedge clk) begin
    if (enq_s && !q.flush) begin
      mem_q[wr_ptr_q] <= '{instr: q.in_instr, pc: q.in_pc, pc_plus_4: q.in_pc + XLEN'(4)};
    end
  end

  assign q.in_ready      = !full_s;
  assign q.out_valid     = !empty_s;
  assign q.out_instr     = empty_s ? {XLEN{1'b0}} : head_s.instr;
  assign q.out_pc        = empty_s ? {XLEN{1'b0}} : head_s.pc;
  assign q.out_pc_plus_4 = empty_s ? {XLEN{1'b0}} : head_s.pc_plus_4;
  assign q.count         = count_q;
  assign q.almost_full   = (count_q >= CNT_W'(AF_LEVEL));

  if_queue_chk #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .wr_ptr_i (wr_ptr_q),
    .rd_ptr_i (rd_ptr_q),
    .count_i  (count_q)
  );
endmodule

// Occupancy and pointer-consistency invariants of the queue.
module if_queue_chk #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             reset,
  input logic [PTR_W-1:0] wr_ptr_i,
  input logic [PTR_W-1:0] rd_ptr_i,
  input logic [CNT_W-1:0] count_i
);
  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count_i <= CNT_W'(DEPTH));

  a_ptr_distance: assert property (@(posedge clk) disable iff (!reset)
    PTR_W'(wr_ptr_i - rd_ptr_i) == count_i[PTR_W-1:0]);
endmodule

// File: tb/tb_if_queue.sv
// Directed bench for if_queue: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_if_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int AF    = DEPTH - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   running = 1'b0;

  if_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) qif ();

  if_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (qif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: a plain FIFO of {instr, pc, pc+4}
  logic [95:0] mq [$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
    end else if (qif.flush) begin
      mq.delete();
    end else begin
      bit do_deq, do_enq;
      do_deq = (mq.size() != 0) && qif.out_ready;
      do_enq = qif.in_valid && (mq.size() < DEPTH);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back({qif.in_instr, qif.in_pc, qif.in_pc + 32'd4});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, half a period after each edge
  always @(negedge clk) begin
    if (running) begin
      logic [95:0] h;
      h = (mq.size() != 0) ? mq[0] : 96'd0;
      chk("m_out_valid", 32'(qif.out_valid), 32'(mq.size() != 0));
      chk("m_in_ready", 32'(qif.in_ready), 32'(mq.size() < DEPTH));
      chk("m_count", 32'(qif.count), 32'(mq.size()));
      chk("m_almost_full", 32'(qif.almost_full), 32'(mq.size() >= AF));
      chk("m_out_instr", qif.out_instr, h[95:64]);
      chk("m_out_pc", qif.out_pc, h[63:32]);
      chk("m_out_pc4", qif.out_pc_plus_4, h[31:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    qif.in_valid  = v;
    qif.in_instr  = instr;
    qif.in_pc     = pc;
    qif.out_ready = ordy;
    qif.flush     = fl;
  endtask

  initial begin
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    running = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(qif.out_valid), 32'd0);
    chk("rst_in_ready", 32'(qif.in_ready), 32'd1);
    chk("rst_almost_full", 32'(qif.almost_full), 32'd0);
    chk("rst_count", 32'(qif.count), 32'd0);
    chk("rst_out_instr", qif.out_instr, 32'd0);
    reset = 1'b1;
    step();

    // 1: single enqueue, visible after one edge
    drive(1'b1, 32'h0050_0093, 32'h0000_0000, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t1_out_valid", 32'(qif.out_valid), 32'd1);
    chk("t1_out_instr", qif.out_instr, 32'h0050_0093);
    chk("t1_out_pc", qif.out_pc, 32'h0000_0000);
    chk("t1_out_pc4", qif.out_pc_plus_4, 32'h0000_0004);
    chk("t1_count", 32'(qif.count), 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t1_flush_count", 32'(qif.count), 32'd0);

    // 2: fill while decode is stalled, then release one slot
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000_0000 + 32'(4 * i), 32'(4 * i), 1'b0, 1'b0);
      step();
      if (i == 1) chk("t2_af_at_2", 32'(qif.almost_full), 32'd0);
      if (i == 2) chk("t2_af_at_3", 32'(qif.almost_full), 32'd1);
    end
    drive(1'b1, 32'h1000_0010, 32'h0000_0010, 1'b0, 1'b0);
    chk("t2_full_count", 32'(qif.count), 32'd4);
    chk("t2_full_in_ready", 32'(qif.in_ready), 32'd0);
    step();
    chk("t2_held_count", 32'(qif.count), 32'd4);
    chk("t2_held_head", qif.out_pc, 32'h0000_0000);
    drive(1'b1, 32'h1000_0010, 32'h0000_0010, 1'b1, 1'b0);
    step();
    chk("t2_deq_count", 32'(qif.count), 32'd3);
    chk("t2_deq_head", qif.out_pc, 32'h0000_0004);
    chk("t2_deq_in_ready", 32'(qif.in_ready), 32'd1);
    drive(1'b1, 32'h1000_0010, 32'h0000_0010, 1'b0, 1'b0);
    step();
    chk("t2_acc_count", 32'(qif.count), 32'd4);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      chk("t2_drain_pc", qif.out_pc, 32'(4 + 4 * j));
      step();
    end
    chk("t2_drained", 32'(qif.out_valid), 32'd0);

    // 3: streaming through, occupancy steady at one
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h2000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      step();
      chk("t3_count", 32'(qif.count), 32'd1);
      chk("t3_head_pc", qif.out_pc, 32'h100 + 32'(4 * i));
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    chk("t3_empty", 32'(qif.count), 32'd0);

    // 4: flush with simultaneous enqueue and dequeue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000_0000 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    chk("t4_pre_count", 32'(qif.count), 32'd3);
    drive(1'b1, 32'h3000_00FF, 32'h0000_030C, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t4_count", 32'(qif.count), 32'd0);
    chk("t4_out_valid", 32'(qif.out_valid), 32'd0);
    chk("t4_out_instr", qif.out_instr, 32'd0);
    drive(1'b1, 32'h4000_0001, 32'h0000_0200, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t4_new_head", qif.out_pc, 32'h0000_0200);
    chk("t4_new_count", 32'(qif.count), 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();

    // 5: PC+4 wraps modulo 2^32
    drive(1'b1, 32'h5000_0001, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step();
    chk("t5_pc4_wrap", qif.out_pc_plus_4, 32'h0000_0000);
    drive(1'b1, 32'h5000_0002, 32'h0000_0400, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t6_pre_count", 32'(qif.count), 32'd2);

    // 6: asynchronous reset between edges
    #1 reset = 1'b0;
    #1;
    chk("t6_out_valid", 32'(qif.out_valid), 32'd0);
    chk("t6_count", 32'(qif.count), 32'd0);
    chk("t6_in_ready", 32'(qif.in_ready), 32'd1);
    step();
    reset = 1'b1;
    drive(1'b1, 32'h6000_0001, 32'h0000_0500, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t6_after_head", qif.out_pc, 32'h0000_0500);
    step();

    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
